// File: rtl/sensor_meas_sched_pkg.sv
// Shared types and constants for the sensor measurement scheduler.
package sensor_meas_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_REQ         = 3'd1,
    ST_WAIT_DONE   = 3'd2,
    ST_BACKOFF     = 3'd3,
    ST_WAIT_PERIOD = 3'd4,
    ST_FAULT       = 3'd5
  } state_e;

  localparam int CODE_W = 16;
  localparam int SUM_W  = 18;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sensor_meas_sched_if.sv
// Scheduler <-> I2C engine / display path bus. master = scheduler, slave = engine + consumer.
interface sensor_meas_sched_if;
  import sensor_meas_sched_pkg::*;

  logic              meas_req;
  logic              meas_done;
  logic              meas_err;
  logic [CODE_W-1:0] t_code_in;
  logic [CODE_W-1:0] h_code_in;
  logic [CODE_W-1:0] t_code;
  logic [CODE_W-1:0] h_code;
  logic              data_vld;

  modport master (
    output meas_req, t_code, h_code, data_vld,
    input  meas_done, meas_err, t_code_in, h_code_in
  );

  modport slave (
    input  meas_req, t_code, h_code, data_vld,
    output meas_done, meas_err, t_code_in, h_code_in
  );

endinterface

// File: rtl/sensor_meas_sched_timer.sv
// Loadable down-counter: load with N, expire pulses on the N-th cycle after the load.
module sched_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt_q;
  logic         armed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else if (load) begin
      cnt_q   <= load_val - W'(1);
      armed_q <= 1'b1;
    end else if (armed_q) begin
      if (cnt_q == '0) armed_q <= 1'b0;
      else             cnt_q   <= cnt_q - W'(1);
    end
  end

  assign expire = armed_q && (cnt_q == '0);

endmodule

// File: rtl/sensor_meas_sched.sv
// Periodic sensor measurement scheduler with timeout, retry/back-off and fault latch.
// Define SENSOR_AVG_EN to output the mean of the last 4 accepted samples instead of the latest one.
module sensor_meas_sched
  import sensor_meas_sched_pkg::*;
#(
  parameter int PERIOD_CYC    = 50_000_000,
  parameter int TIMEOUT_CYC   = 5_000_000,
  parameter int RETRY_GAP_CYC = 500_000,
  parameter int MAX_RETRY     = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_en,
  sensor_meas_sched_if.master sif,
  output logic                busy,
  output logic                fault,
  output logic [7:0]          err_cnt
);

  localparam int TIMER_W = $clog2(max3(PERIOD_CYC, TIMEOUT_CYC, RETRY_GAP_CYC) + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam logic [TIMER_W-1:0] LD_TIMEOUT = TIMER_W'(TIMEOUT_CYC);
  localparam logic [TIMER_W-1:0] LD_GAP     = TIMER_W'(RETRY_GAP_CYC);
  localparam logic [TIMER_W-1:0] LD_PERIOD  = TIMER_W'(PERIOD_CYC);

  state_e               state_q, state_d;
  logic                 busy_q, fault_q, data_vld_q;
  logic [RETRY_W-1:0]   retry_q;
  logic [7:0]           err_cnt_q;
  logic [CODE_W-1:0]    t_code_q, h_code_q;
  logic                 accept, fail;
  logic                 tmr_load, tmr_exp;
  logic [TIMER_W-1:0]   tmr_val;

  sched_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // A started transaction always runs to completion; start_en only picks where it lands.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    fail    = 1'b0;
    case (state_q)
      ST_IDLE:      if (start_en) state_d = ST_REQ;
      ST_REQ:       state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (sif.meas_done && !sif.meas_err) begin
          accept  = 1'b1;
          state_d = start_en ? ST_WAIT_PERIOD : ST_IDLE;
        end else if (sif.meas_err || tmr_exp) begin
          fail = 1'b1;
          if (!start_en)                              state_d = ST_IDLE;
          else if (retry_q == RETRY_W'(MAX_RETRY - 1)) state_d = ST_FAULT;
          else                                        state_d = ST_BACKOFF;
        end
      end
      ST_BACKOFF, ST_WAIT_PERIOD: begin
        if (!start_en)    state_d = ST_IDLE;
        else if (tmr_exp) state_d = ST_REQ;
      end
      ST_FAULT:     if (!start_en) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sif.meas_req = (state_q == ST_REQ);
    tmr_load     = 1'b0;
    tmr_val      = LD_TIMEOUT;
    if (state_d != state_q) begin
      case (state_d)
        ST_WAIT_DONE:   begin tmr_load = 1'b1; tmr_val = LD_TIMEOUT; end
        ST_BACKOFF:     begin tmr_load = 1'b1; tmr_val = LD_GAP;     end
        ST_WAIT_PERIOD: begin tmr_load = 1'b1; tmr_val = LD_PERIOD;  end
        default:        ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= 1'b0;
      fault_q   <= 1'b0;
      retry_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      busy_q  <= (state_d == ST_REQ) || (state_d == ST_WAIT_DONE);
      fault_q <= (state_d == ST_FAULT);
      if (state_d == ST_IDLE || accept) retry_q <= '0;
      else if (fail)                    retry_q <= retry_q + RETRY_W'(1);
      if (fail && err_cnt_q != 8'hFF)   err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

`ifdef SENSOR_AVG_EN
  logic [CODE_W-1:0] t_buf [4];
  logic [CODE_W-1:0] h_buf [4];
  logic [SUM_W-1:0]  t_sum_p0, h_sum_p0;
  logic              vld_p0, prefill_q;

  function automatic logic [CODE_W-1:0] avg4(input logic [SUM_W-1:0] sum);
    return sum[CODE_W+1:2];
  endfunction

  // Stage p0: sample window and running sums; the first sample after IDLE fills the whole window.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (prefill_q) begin
        for (int i = 0; i < 4; i++) begin
          t_buf[i] <= sif.t_code_in;
          h_buf[i] <= sif.h_code_in;
        end
        t_sum_p0 <= {sif.t_code_in, 2'b00};
        h_sum_p0 <= {sif.h_code_in, 2'b00};
      end else begin
        t_buf[0] <= sif.t_code_in;
        h_buf[0] <= sif.h_code_in;
        for (int i = 1; i < 4; i++) begin
          t_buf[i] <= t_buf[i-1];
          h_buf[i] <= h_buf[i-1];
        end
        t_sum_p0 <= t_sum_p0 - SUM_W'(t_buf[3]) + SUM_W'(sif.t_code_in);
        h_sum_p0 <= h_sum_p0 - SUM_W'(h_buf[3]) + SUM_W'(sif.h_code_in);
      end
    end
  end

  // Stage p1: divide by 4 and publish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0     <= 1'b0;
      prefill_q  <= 1'b1;
      data_vld_q <= 1'b0;
      t_code_q   <= '0;
      h_code_q   <= '0;
    end else begin
      vld_p0     <= accept;
      prefill_q  <= (state_q == ST_IDLE) || (prefill_q && !accept);
      data_vld_q <= vld_p0;
      if (vld_p0) begin
        t_code_q <= avg4(t_sum_p0);
        h_code_q <= avg4(h_sum_p0);
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_vld_q <= 1'b0;
      t_code_q   <= '0;
      h_code_q   <= '0;
    end else begin
      data_vld_q <= accept;
      if (accept) begin
        t_code_q <= sif.t_code_in;
        h_code_q <= sif.h_code_in;
      end
    end
  end
`endif

  assign sif.t_code   = t_code_q;
  assign sif.h_code   = h_code_q;
  assign sif.data_vld = data_vld_q;
  assign busy         = busy_q;
  assign fault        = fault_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_sensor_meas_sched.sv
// Directed + randomized bench for sensor_meas_sched against a transaction-level reference model.
module tb_sensor_meas_sched;

  localparam int PER  = 100;
  localparam int TO   = 20;
  localparam int GAP  = 10;
  localparam int MAXR = 3;
  localparam int K_DONE = 0, K_ERR = 1, K_SILENT = 2, K_BOTH = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_en;
  logic       busy, fault;
  logic [7:0] err_cnt;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;

  sensor_meas_sched_if sif ();

  sensor_meas_sched #(
    .PERIOD_CYC    (PER),
    .TIMEOUT_CYC   (TO),
    .RETRY_GAP_CYC (GAP),
    .MAX_RETRY     (MAXR)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_en (start_en),
    .sif      (sif),
    .busy     (busy),
    .fault    (fault),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [15:0] exp_t, exp_h;
  int          exp_err, retry_m;
  logic        exp_fault, prefill_m;
`ifdef SENSOR_AVG_EN
  int st[4], sh[4];
`endif

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_accept(input logic [15:0] t, input logic [15:0] h);
`ifdef SENSOR_AVG_EN
    if (prefill_m) begin
      for (int i = 0; i < 4; i++) begin st[i] = int'(t); sh[i] = int'(h); end
    end else begin
      for (int i = 3; i > 0; i--) begin st[i] = st[i-1]; sh[i] = sh[i-1]; end
      st[0] = int'(t); sh[0] = int'(h);
    end
    exp_t = 16'((st[0] + st[1] + st[2] + st[3]) / 4);
    exp_h = 16'((sh[0] + sh[1] + sh[2] + sh[3]) / 4);
`else
    exp_t = t;
    exp_h = h;
`endif
    prefill_m = 1'b0;
    retry_m   = 0;
  endtask

  task automatic expect_req(input int at, input string tag);
    while (sif.meas_req !== 1'b1 && cyc < at + 3) tick();
    chk(tag, 32'(cyc), 32'(at));
  endtask

  task automatic no_req(input int n, input string tag);
    int c;
    c = 0;
    repeat (n) begin
      tick();
      if (sif.meas_req === 1'b1) c++;
    end
    chk(tag, 32'(c), 32'd0);
  endtask

  // Called on the cycle meas_req is seen; returns the cycle of the next expected request or -1.
  task automatic txn(input int kind, input int d, input int drop,
                     input logic [15:0] t, input logic [15:0] h, output int nr);
    int n;
    chk("busy_in_req", 32'(busy), 32'd1);
    if (kind == K_SILENT) begin
      repeat (TO) tick();
    end else begin
      for (int i = 1; i <= d; i++) begin
        tick();
        if (i == drop) start_en = 1'b0;
      end
      sif.meas_done = (kind == K_DONE) || (kind == K_BOTH);
      sif.meas_err  = (kind != K_DONE);
      sif.t_code_in = t;
      sif.h_code_in = h;
    end
    n = cyc;
    chk("busy_in_wait", 32'(busy), 32'd1);
    tick();
    sif.meas_done = 1'b0;
    sif.meas_err  = 1'b0;
    if (kind == K_DONE) begin
      model_accept(t, h);
`ifdef SENSOR_AVG_EN
      chk("vld_not_early", 32'(sif.data_vld), 32'd0);
      tick();
`endif
      chk("vld_pulse", 32'(sif.data_vld), 32'd1);
      chk("t_code", 32'(sif.t_code), 32'(exp_t));
      chk("h_code", 32'(sif.h_code), 32'(exp_h));
      chk("busy_after_done", 32'(busy), 32'd0);
      chk("fault_after_done", 32'(fault), 32'(exp_fault));
      tick();
      chk("vld_one_cycle", 32'(sif.data_vld), 32'd0);
      nr = start_en ? n + PER + 1 : -1;
    end else begin
      if (exp_err < 255) exp_err++;
      retry_m++;
      if (!start_en)             nr = -1;
      else if (retry_m == MAXR) begin exp_fault = 1'b1; nr = -1; end
      else                       nr = n + GAP + 1;
      chk("vld_on_fail", 32'(sif.data_vld), 32'd0);
      chk("err_cnt", 32'(err_cnt), 32'(exp_err));
      chk("fault", 32'(fault), 32'(exp_fault));
      chk("t_hold_on_fail", 32'(sif.t_code), 32'(exp_t));
      chk("busy_after_fail", 32'(busy), 32'd0);
    end
    if (!start_en) begin
      retry_m   = 0;
      prefill_m = 1'b1;
    end
  endtask

  task automatic recover();
    start_en = 1'b0;
    tick();
    exp_fault = 1'b0;
    retry_m   = 0;
    prefill_m = 1'b1;
    chk("fault_cleared", 32'(fault), 32'd0);
    start_en = 1'b1;
    expect_req(cyc + 1, "req_after_clear");
  endtask

  initial begin
    int nr, kind, d, extra;
    logic [15:0] rt, rh;

    rst_n = 1'b0; start_en = 1'b0;
    sif.meas_done = 1'b0; sif.meas_err = 1'b0;
    sif.t_code_in = '0; sif.h_code_in = '0;
    exp_t = '0; exp_h = '0; exp_err = 0; retry_m = 0;
    exp_fault = 1'b0; prefill_m = 1'b1;
    repeat (3) tick();
    chk("rst_meas_req", 32'(sif.meas_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_t_code", 32'(sif.t_code), 32'd0);
    chk("rst_vld", 32'(sif.data_vld), 32'd0);
    rst_n = 1'b1;
    tick();

    // Normal measurement and period spacing
    start_en = 1'b1;
    expect_req(cyc + 1, "first_req");
    txn(K_DONE, 5, 0, 16'h6666, 16'h8000, nr);
    expect_req(nr, "period_req");

    // Silent engine -> timeouts -> fault
    txn(K_SILENT, 0, 0, 16'h0, 16'h0, nr);
    expect_req(nr, "retry_req1");
    txn(K_SILENT, 0, 0, 16'h0, 16'h0, nr);
    expect_req(nr, "retry_req2");
    txn(K_SILENT, 0, 0, 16'h0, 16'h0, nr);
    chk("fault_no_next", 32'(nr), 32'hFFFF_FFFF);
    no_req(60, "no_req_in_fault");
    recover();

    // Error then success, then two failures + success: no fault
    txn(K_ERR, 3, 0, 16'($urandom), 16'($urandom), nr);
    expect_req(nr, "s3_retry");
    txn(K_DONE, $urandom_range(1, 18), 0, 16'($urandom), 16'($urandom), nr);
    expect_req(nr, "s3_period");
    txn(K_ERR, $urandom_range(1, 18), 0, 16'($urandom), 16'($urandom), nr);
    expect_req(nr, "s3_retry2");
    txn(K_SILENT, 0, 0, 16'h0, 16'h0, nr);
    expect_req(nr, "s3_retry3");
    txn(K_DONE, $urandom_range(1, 18), 0, 16'($urandom), 16'($urandom), nr);
    expect_req(nr, "s3_period2");

    // done+err together, then stray done during WAIT_PERIOD
    txn(K_BOTH, $urandom_range(1, 18), 0, 16'($urandom), 16'($urandom), nr);
    expect_req(nr, "both_backoff");
    txn(K_DONE, $urandom_range(1, 18), 0, 16'($urandom), 16'($urandom), nr);
    repeat (10) tick();
    sif.meas_done = 1'b1; sif.t_code_in = ~exp_t; sif.h_code_in = ~exp_h;
    tick();
    sif.meas_done = 1'b0;
    chk("stray_vld", 32'(sif.data_vld), 32'd0);
    tick();
    chk("stray_vld2", 32'(sif.data_vld), 32'd0);
    chk("stray_t_hold", 32'(sif.t_code), 32'(exp_t));
    expect_req(nr, "after_stray_req");

    // Randomized transactions
    for (int i = 0; i < 12; i++) begin
      kind = $urandom_range(0, 3);
      d    = $urandom_range(1, 18);
      rt   = 16'($urandom);
      rh   = 16'($urandom);
      txn(kind, d, 0, rt, rh, nr);
      if (nr < 0) recover();
      else        expect_req(nr, "rnd_req");
    end

    // Drive err_cnt into saturation
    extra = 0;
    for (int i = 0; i < 400 && extra < 3; i++) begin
      txn(K_ERR, 1, 0, 16'h0, 16'h0, nr);
      if (exp_err == 255) extra++;
      if (nr < 0) recover();
      else        expect_req(nr, "sat_req");
    end
    chk("err_cnt_sat", 32'(err_cnt), 32'd255);

    // start_en dropped mid-transaction: completes, latches, then stops
    txn(K_DONE, 10, 4, 16'($urandom), 16'($urandom), nr);
    chk("drop_no_next", 32'(nr), 32'hFFFF_FFFF);
    no_req(150, "no_req_after_drop");

    // Async reset in WAIT_DONE, then late engine pulses ignored
    start_en = 1'b1;
    expect_req(cyc + 1, "req_before_rst");
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_meas_req", 32'(sif.meas_req), 32'd0);
    chk("arst_err_cnt", 32'(err_cnt), 32'd0);
    chk("arst_t_code", 32'(sif.t_code), 32'd0);
    chk("arst_h_code", 32'(sif.h_code), 32'd0);
    chk("arst_fault", 32'(fault), 32'd0);
    chk("arst_vld", 32'(sif.data_vld), 32'd0);
    exp_err = 0; exp_t = '0; exp_h = '0; retry_m = 0; prefill_m = 1'b1;
    start_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    sif.meas_done = 1'b1; sif.t_code_in = 16'h1234; sif.h_code_in = 16'h5678;
    tick();
    sif.meas_done = 1'b0; sif.meas_err = 1'b1;
    tick();
    sif.meas_err = 1'b0;
    chk("late_done_vld", 32'(sif.data_vld), 32'd0);
    tick();
    chk("late_done_vld2", 32'(sif.data_vld), 32'd0);
    chk("late_done_t", 32'(sif.t_code), 32'd0);
    chk("late_err_cnt", 32'(err_cnt), 32'd0);
    chk("late_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
